// File: rtl/note_sched_pkg.sv
// Shared definitions for the falling-note scheduler.
// Holds the sequencer state encoding, the default playfield geometry and the
// width of every slot position register.
package note_sched_pkg;

  // Width of one slot position; 10 bits covers rows 0..1023.
  localparam int unsigned PosW = 10;

  // Default playfield geometry (rows).
  localparam int unsigned DefYMax   = 520;
  localparam int unsigned DefSpawnY = 0;
  localparam int unsigned DefHitLo  = 440;
  localparam int unsigned DefHitHi  = 500;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/lane_slot_bank.sv
// One lane of note slots.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   clear_i        - drop every slot (new song)
//   en_i           - movement and hits enabled (RUN or DRAIN)
//   tick_i         - advance every active slot by one row
//   hit_i          - player press on this lane
//   spawn_i        - allocate a note in the lowest free slot
//   pos_o          - packed slot positions, slot s at [s*PosW +: PosW]
//   active_o       - slot valid flags
//   hit_ok_o       - a press retired a slot this cycle
//   miss_cnt_o     - slots retired at the bottom this cycle
//   full_o         - no free slot in the pre-cycle flags
module lane_slot_bank
  import note_sched_pkg::*;
#(
  parameter int unsigned SLOTS   = 3,
  parameter int unsigned Y_MAX   = DefYMax,
  parameter int unsigned SPAWN_Y = DefSpawnY,
  parameter int unsigned HIT_LO  = DefHitLo,
  parameter int unsigned HIT_HI  = DefHitHi
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         en_i,
  input  logic                         tick_i,
  input  logic                         hit_i,
  input  logic                         spawn_i,
  output logic [SLOTS*PosW-1:0]        pos_o,
  output logic [SLOTS-1:0]             active_o,
  output logic                         hit_ok_o,
  output logic [$clog2(SLOTS+1)-1:0]   miss_cnt_o,
  output logic                         full_o
);

  localparam int unsigned MissW = $clog2(SLOTS + 1);
  localparam logic [PosW-1:0] YMax   = PosW'(Y_MAX);
  localparam logic [PosW-1:0] SpawnY = PosW'(SPAWN_Y);
  localparam logic [PosW-1:0] HitLo  = PosW'(HIT_LO);
  localparam logic [PosW-1:0] HitHi  = PosW'(HIT_HI);

  logic [SLOTS-1:0][PosW-1:0] pos_q, pos_d;
  logic [SLOTS-1:0]           act_q, act_d;
  logic [SLOTS-1:0]           hit_sel, spawn_sel;
  logic                       found, free_found;
  logic [PosW-1:0]            sel_pos;
  logic [MissW-1:0]           miss_cnt;

  // Hit target: deepest in-window slot; strict '>' keeps the lowest index on ties.
  always_comb begin
    found   = 1'b0;
    sel_pos = '0;
    hit_sel = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (act_q[s] && pos_q[s] >= HitLo && pos_q[s] <= HitHi &&
          (!found || pos_q[s] > sel_pos)) begin
        found      = 1'b1;
        sel_pos    = pos_q[s];
        hit_sel    = '0;
        hit_sel[s] = 1'b1;
      end
    end
  end

  // Spawn target: lowest slot free in the pre-cycle flags, so a slot retired
  // this cycle is never reused until the next one.
  always_comb begin
    free_found = 1'b0;
    spawn_sel  = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (!act_q[s] && !free_found) begin
        free_found   = 1'b1;
        spawn_sel[s] = 1'b1;
      end
    end
  end

  always_comb begin
    act_d    = act_q;
    pos_d    = pos_q;
    miss_cnt = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (act_q[s]) begin
        if (en_i && hit_i && hit_sel[s]) begin
          act_d[s] = 1'b0;
        end else if (en_i && tick_i) begin
          if (pos_q[s] == YMax) begin
            act_d[s] = 1'b0;
            miss_cnt = miss_cnt + MissW'(1);
          end else begin
            pos_d[s] = pos_q[s] + PosW'(1);
          end
        end
      end else if (spawn_i && spawn_sel[s]) begin
        act_d[s] = 1'b1;
        pos_d[s] = SpawnY;
      end
    end
    if (clear_i) begin
      act_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q <= '0;
      act_q <= '0;
    end else begin
      pos_q <= pos_d;
      act_q <= act_d;
    end
  end

  assign pos_o      = pos_q;
  assign active_o   = act_q;
  assign hit_ok_o   = en_i & hit_i & found;
  assign miss_cnt_o = miss_cnt;
  assign full_o     = &act_q;

endmodule

// File: rtl/note_lane_scheduler.sv
// Falling-note sequencer: fetches one pattern word per beat, spawns notes into
// per-lane slot banks, moves them on ticks and scores hits and misses.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   start                - level, starts a song from IDLE or DONE
//   tick, beat, hit      - movement, spawn and per-lane press pulses
//   pattern_data/_addr   - asynchronous pattern ROM interface
//   pos, active          - slot positions and valid flags for the pixel logic
//   score, misses        - saturating counters
//   overflow             - sticky, a spawn found its lane full
//   state                - IDLE=0, RUN=1, DRAIN=2, DONE=3
module note_lane_scheduler
  import note_sched_pkg::*;
#(
  parameter int unsigned LANES       = 3,
  parameter int unsigned SLOTS       = 3,
  parameter int unsigned PATTERN_LEN = 8,
  parameter int unsigned Y_MAX       = DefYMax,
  parameter int unsigned SPAWN_Y     = DefSpawnY,
  parameter int unsigned HIT_LO      = DefHitLo,
  parameter int unsigned HIT_HI      = DefHitHi
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           tick,
  input  logic                           beat,
  input  logic [LANES-1:0]               hit,
  input  logic [LANES-1:0]               pattern_data,
  output logic [$clog2(PATTERN_LEN)-1:0] pattern_addr,
  output logic [LANES*SLOTS*PosW-1:0]    pos,
  output logic [LANES*SLOTS-1:0]         active,
  output logic [7:0]                     score,
  output logic [7:0]                     misses,
  output logic                           overflow,
  output logic [1:0]                     state
);

  localparam int unsigned AddrW = $clog2(PATTERN_LEN);
  localparam int unsigned MissW = $clog2(SLOTS + 1);
  localparam logic [AddrW-1:0] AddrLast = AddrW'(PATTERN_LEN - 1);

  state_e               state_q;
  logic [AddrW-1:0]     addr_q;
  logic [7:0]           score_q, misses_q;
  logic                 overflow_q;

  logic                 run_en, clear_all;
  logic [LANES-1:0]     spawn, hit_ok, full;
  logic [LANES-1:0][MissW-1:0] miss_cnt;
  // Wide enough to sum every lane's events without wrapping before saturation.
  logic [9:0]           hit_sum, miss_sum, score_sum, miss_tot;
  logic [7:0]           score_nxt, misses_nxt;

  assign run_en    = (state_q == StRun) || (state_q == StDrain);
  assign clear_all = ((state_q == StIdle) || (state_q == StDone)) && start;
  assign spawn     = {LANES{(state_q == StRun) && beat}} & pattern_data;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_slot_bank #(
      .SLOTS  (SLOTS),
      .Y_MAX  (Y_MAX),
      .SPAWN_Y(SPAWN_Y),
      .HIT_LO (HIT_LO),
      .HIT_HI (HIT_HI)
    ) u_bank (
      .clk_i     (clk),
      .rst_ni    (reset),
      .clear_i   (clear_all),
      .en_i      (run_en),
      .tick_i    (tick),
      .hit_i     (hit[l]),
      .spawn_i   (spawn[l]),
      .pos_o     (pos[l*SLOTS*PosW +: SLOTS*PosW]),
      .active_o  (active[l*SLOTS +: SLOTS]),
      .hit_ok_o  (hit_ok[l]),
      .miss_cnt_o(miss_cnt[l]),
      .full_o    (full[l])
    );
  end

  always_comb begin
    hit_sum  = '0;
    miss_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      hit_sum  = hit_sum + 10'(hit_ok[l]);
      miss_sum = miss_sum + 10'(miss_cnt[l]);
    end
    score_sum  = {2'b00, score_q} + hit_sum;
    miss_tot   = {2'b00, misses_q} + miss_sum;
    score_nxt  = (score_sum > 10'd255) ? 8'd255 : score_sum[7:0];
    misses_nxt = (miss_tot > 10'd255) ? 8'd255 : miss_tot[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      score_q    <= '0;
      misses_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StRun;
            addr_q     <= '0;
            score_q    <= '0;
            misses_q   <= '0;
            overflow_q <= 1'b0;
          end
        end
        StRun: begin
          if (beat) begin
            if (addr_q == AddrLast) state_q <= StDrain;
            else                    addr_q  <= addr_q + AddrW'(1);
          end
          if (|(spawn & full)) overflow_q <= 1'b1;
          score_q  <= score_nxt;
          misses_q <= misses_nxt;
        end
        StDrain: begin
          if (active == '0) state_q <= StDone;
          score_q  <= score_nxt;
          misses_q <= misses_nxt;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pattern_addr = addr_q;
  assign score        = score_q;
  assign misses       = misses_q;
  assign overflow     = overflow_q;
  assign state        = state_q;

endmodule

// File: tb/tb_note_lane_scheduler.sv
module tb_note_lane_scheduler;

  logic        clk, reset, start, tick, beat;
  logic [2:0]  hit, pattern_data;
  logic [2:0]  pattern_addr;
  logic [89:0] pos;
  logic [8:0]  active;
  logic [7:0]  score, misses;
  logic        overflow;
  logic [1:0]  state;

  int checks = 0;
  int passed = 0;

  note_lane_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .tick        (tick),
    .beat        (beat),
    .hit         (hit),
    .pattern_data(pattern_data),
    .pattern_addr(pattern_addr),
    .pos         (pos),
    .active      (active),
    .score       (score),
    .misses      (misses),
    .overflow    (overflow),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] pos_of(input int l, input int s);
    return pos[(l*3+s)*10 +: 10];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic t, input logic b, input logic [2:0] h, input logic [2:0] pd);
    tick = t; beat = b; hit = h; pattern_data = pd;
    cyc();
    tick = 1'b0; beat = 1'b0; hit = 3'b000; pattern_data = 3'b000;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 3'b000, 3'b000);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic start_run();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; tick = 1'b0; beat = 1'b0; hit = '0; pattern_data = '0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    checks++; if (pos !== '0) $display("FAIL rst_pos: got %h want 0", pos); else passed++;
    checks++; if (active !== 9'd0) $display("FAIL rst_active: got %b want 0", active); else passed++;
    checks++; if (score !== 8'd0) $display("FAIL rst_score: got %0d want 0", score); else passed++;
    checks++; if (misses !== 8'd0) $display("FAIL rst_misses: got %0d want 0", misses); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow); else passed++;
    checks++; if (pattern_addr !== 3'd0) $display("FAIL rst_addr: got %0d want 0", pattern_addr); else passed++;
    checks++; if (state !== 2'd0) $display("FAIL rst_state: got %0d want 0", state); else passed++;
  endtask

  task automatic test_spawn();
    start_run();
    checks++; if (state !== 2'd1) $display("FAIL spawn_run: got %0d want 1", state); else passed++;
    pulse(1'b0, 1'b1, 3'b000, 3'b001);
    checks++; if (active !== 9'b000_000_001) $display("FAIL spawn_active: got %b want 000000001", active); else passed++;
    checks++; if (pos_of(0, 0) !== 10'd0) $display("FAIL spawn_pos: got %0d want 0", pos_of(0, 0)); else passed++;
    checks++; if (pattern_addr !== 3'd1) $display("FAIL spawn_addr: got %0d want 1", pattern_addr); else passed++;
    ticks(10);
    checks++; if (pos_of(0, 0) !== 10'd10) $display("FAIL advance_pos: got %0d want 10", pos_of(0, 0)); else passed++;
    checks++; if (pattern_addr !== 3'd1) $display("FAIL advance_addr: got %0d want 1", pattern_addr); else passed++;
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    #2;
    checks++; if (active !== 9'd0) $display("FAIL mid_active: got %b want 0", active); else passed++;
    checks++; if (pos !== '0) $display("FAIL mid_pos: got %h want 0", pos); else passed++;
    checks++; if (pattern_addr !== 3'd0) $display("FAIL mid_addr: got %0d want 0", pattern_addr); else passed++;
    checks++; if (state !== 2'd0) $display("FAIL mid_state: got %0d want 0", state); else passed++;
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_overflow();
    start_run();
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 3'b000, 3'b100);
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", overflow); else passed++;
    checks++; if (active !== 9'b111_000_000) $display("FAIL ovf_fill: got %b want 111000000", active); else passed++;
    pulse(1'b0, 1'b1, 3'b000, 3'b100);
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else passed++;
    checks++; if (active !== 9'b111_000_000) $display("FAIL ovf_active: got %b want 111000000", active); else passed++;
    checks++; if (pattern_addr !== 3'd4) $display("FAIL ovf_addr: got %0d want 4", pattern_addr); else passed++;
  endtask

  task automatic test_hit_window();
    do_reset();
    start_run();
    pulse(1'b0, 1'b1, 3'b000, 3'b010);
    ticks(439);
    checks++; if (pos_of(1, 0) !== 10'd439) $display("FAIL hw_pos439: got %0d want 439", pos_of(1, 0)); else passed++;
    pulse(1'b0, 1'b0, 3'b010, 3'b000);
    checks++; if (score !== 8'd0) $display("FAIL hw_early_score: got %0d want 0", score); else passed++;
    checks++; if (active !== 9'b000_001_000) $display("FAIL hw_early_active: got %b want 000001000", active); else passed++;
    ticks(1);
    pulse(1'b0, 1'b0, 3'b010, 3'b000);
    checks++; if (score !== 8'd1) $display("FAIL hw_hit_score: got %0d want 1", score); else passed++;
    checks++; if (active !== 9'd0) $display("FAIL hw_hit_active: got %b want 0", active); else passed++;
    pulse(1'b0, 1'b0, 3'b010, 3'b000);
    checks++; if (score !== 8'd1) $display("FAIL hw_rehit_score: got %0d want 1", score); else passed++;
  endtask

  task automatic test_hit_select();
    do_reset();
    start_run();
    pulse(1'b0, 1'b1, 3'b000, 3'b110);
    pulse(1'b0, 1'b1, 3'b000, 3'b010);
    ticks(5);
    pulse(1'b0, 1'b1, 3'b000, 3'b010);
    ticks(440);
    checks++; if (pos_of(1, 2) !== 10'd440) $display("FAIL hs_pos: got %0d want 440", pos_of(1, 2)); else passed++;
    // Two lanes score at once; lane 1 ties at 445 between slots 0 and 1.
    pulse(1'b1, 1'b0, 3'b110, 3'b000);
    checks++; if (score !== 8'd2) $display("FAIL hs_two_lane_score: got %0d want 2", score); else passed++;
    checks++; if (active !== 9'b000_110_000) $display("FAIL hs_tie_active: got %b want 000110000", active); else passed++;
    checks++; if (pos_of(1, 1) !== 10'd446) $display("FAIL hs_adv_s1: got %0d want 446", pos_of(1, 1)); else passed++;
    checks++; if (pos_of(1, 2) !== 10'd441) $display("FAIL hs_adv_s2: got %0d want 441", pos_of(1, 2)); else passed++;
    pulse(1'b0, 1'b0, 3'b010, 3'b000);
    checks++; if (active !== 9'b000_100_000) $display("FAIL hs_deepest: got %b want 000100000", active); else passed++;
    pulse(1'b0, 1'b0, 3'b010, 3'b000);
    checks++; if (score !== 8'd4) $display("FAIL hs_final_score: got %0d want 4", score); else passed++;
    checks++; if (active !== 9'd0) $display("FAIL hs_final_active: got %b want 0", active); else passed++;
  endtask

  task automatic test_miss_reuse();
    do_reset();
    start_run();
    pulse(1'b0, 1'b1, 3'b000, 3'b001);
    ticks(5);
    pulse(1'b0, 1'b1, 3'b000, 3'b001);
    ticks(515);
    checks++; if (pos_of(0, 0) !== 10'd520) $display("FAIL mr_bottom_pos: got %0d want 520", pos_of(0, 0)); else passed++;
    checks++; if (misses !== 8'd0) $display("FAIL mr_no_early_miss: got %0d want 0", misses); else passed++;
    pulse(1'b1, 1'b1, 3'b000, 3'b001);
    checks++; if (misses !== 8'd1) $display("FAIL mr_miss: got %0d want 1", misses); else passed++;
    checks++; if (active[2:0] !== 3'b110) $display("FAIL mr_next_free: got %b want 110", active[2:0]); else passed++;
    checks++; if (pos_of(0, 1) !== 10'd516) $display("FAIL mr_s1_adv: got %0d want 516", pos_of(0, 1)); else passed++;
    pulse(1'b0, 1'b1, 3'b000, 3'b001);
    checks++; if (active[2:0] !== 3'b111) $display("FAIL mr_reuse: got %b want 111", active[2:0]); else passed++;
    checks++; if (pos_of(0, 0) !== 10'd0) $display("FAIL mr_reuse_pos: got %0d want 0", pos_of(0, 0)); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL mr_overflow: got %b want 0", overflow); else passed++;
  endtask

  task automatic test_drain();
    int n;
    do_reset();
    start_run();
    for (int i = 0; i < 8; i++) begin
      pulse(1'b0, 1'b1, 3'b000, 3'b111);
      if (i == 6) begin
        checks++; if (state !== 2'd1) $display("FAIL dr_run7: got %0d want 1", state); else passed++;
        checks++; if (pattern_addr !== 3'd7) $display("FAIL dr_addr7: got %0d want 7", pattern_addr); else passed++;
      end
    end
    checks++; if (state !== 2'd2) $display("FAIL dr_enter: got %0d want 2", state); else passed++;
    checks++; if (pattern_addr !== 3'd7) $display("FAIL dr_addr_hold: got %0d want 7", pattern_addr); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL dr_overflow: got %b want 1", overflow); else passed++;
    ticks(440);
    pulse(1'b0, 1'b0, 3'b001, 3'b000);
    checks++; if (score !== 8'd1) $display("FAIL dr_hit: got %0d want 1", score); else passed++;
    pulse(1'b0, 1'b1, 3'b000, 3'b111);
    checks++; if (active !== 9'b111_111_110) $display("FAIL dr_beat_ignored: got %b want 111111110", active); else passed++;
    n = 0;
    while (state !== 2'd3 && n < 200) begin
      pulse(1'b1, 1'b0, 3'b000, 3'b000);
      n++;
    end
    checks++; if (state !== 2'd3) $display("FAIL dr_done: got state %0d want 3", state); else passed++;
    checks++; if (n !== 82) $display("FAIL dr_ticks: got %0d want 82", n); else passed++;
    checks++; if (misses !== 8'd8) $display("FAIL dr_misses: got %0d want 8", misses); else passed++;
    checks++; if (32'(misses) + 32'(score) !== 9) $display("FAIL dr_total: got %0d want 9", misses + score); else passed++;
    pulse(1'b1, 1'b1, 3'b111, 3'b111);
    checks++; if (state !== 2'd3) $display("FAIL done_hold_state: got %0d want 3", state); else passed++;
    checks++; if (active !== 9'd0) $display("FAIL done_hold_active: got %b want 0", active); else passed++;
    start_run();
    checks++; if (state !== 2'd1) $display("FAIL restart_state: got %0d want 1", state); else passed++;
    checks++; if (score !== 8'd0 || misses !== 8'd0) $display("FAIL restart_counters: got %0d/%0d want 0/0", score, misses); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL restart_overflow: got %b want 0", overflow); else passed++;
    checks++; if (pattern_addr !== 3'd0) $display("FAIL restart_addr: got %0d want 0", pattern_addr); else passed++;
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_reset_mid();
    test_overflow();
    test_hit_window();
    test_hit_select();
    test_miss_reuse();
    test_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
